// File: rtl/prog_load_ctrl.sv
// prog_load_ctrl: serial program loader for the instruction memory.
// While the mode switch is on, the CPU is held in reset. The block takes a
// 16-bit big-endian word count N, then 4*N bytes. Each group of four bytes
// becomes one 32-bit big-endian word written to consecutive imem addresses.
//
// Ports:
//   clk, reset      system clock; synchronous active-high reset
//   mode_sw         asynchronous download-mode switch (1 = download)
//   rx_valid/data   one-cycle received-byte strobe and byte
//   cpu_rst         holds CPU in reset (high in every state except IDLE)
//   imem_we/addr/   one-cycle instruction-memory write; addr and data hold
//   imem_wdata      their values between writes
//   busy/done/err   status: header or data phase / load complete / N too big
module prog_load_ctrl #(
  parameter int IMEM_AW    = 14,
  parameter int IMEM_WORDS = 16384
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode_sw,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               cpu_rst,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, DONE, ERR} state_t;

  localparam logic [16:0] MAX_WORDS = 17'(IMEM_WORDS);

  logic               sw_meta_q, sw_s_q;
  state_t             state_q, state_d;
  logic [15:0]        n_q, n_d;
  logic [15:0]        idx_q, idx_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [23:0]        word_q, word_d;   // first three bytes of the word in flight
  logic               we_q, we_d;
  logic [IMEM_AW-1:0] addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               cpu_rst_q, busy_q, done_q, err_q;

  logic [15:0] n_new;
  logic [15:0] idx_inc;
  assign n_new   = {n_q[15:8], rx_data};
  assign idx_inc = idx_q + 16'd1;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: if (sw_s_q) state_d = HDR_HI;
      HDR_HI: begin
        if (!sw_s_q) state_d = IDLE;
        else if (rx_valid) begin
          n_d     = {rx_data, n_q[7:0]};
          state_d = HDR_LO;
        end
      end
      HDR_LO: begin
        if (!sw_s_q) state_d = IDLE;
        else if (rx_valid) begin
          n_d = n_new;
          if (n_new == 16'd0)                  state_d = DONE;
          else if ({1'b0, n_new} > MAX_WORDS)  state_d = ERR;
          else begin
            state_d = DATA;
            idx_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      DATA: begin
        // Switch drop wins over a byte arriving on the same cycle: no write.
        if (!sw_s_q) state_d = IDLE;
        else if (rx_valid) begin
          cnt_d = cnt_q + 2'd1;   // wraps 3 -> 0
          if (cnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = idx_q[IMEM_AW-1:0];
            wdata_d = {word_q, rx_data};
            idx_d   = idx_inc;
            if (idx_inc == n_q) state_d = DONE;
          end else begin
            word_d = {word_q[15:0], rx_data};
          end
        end
      end
      DONE, ERR: if (!sw_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta_q <= 1'b0;
      sw_s_q    <= 1'b0;
      state_q   <= IDLE;
      n_q       <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      word_q    <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sw_meta_q <= mode_sw;
      sw_s_q    <= sw_meta_q;
      state_q   <= state_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      // Status flags decode the next state so they line up with state_q.
      cpu_rst_q <= (state_d != IDLE);
      busy_q    <= (state_d == HDR_HI) || (state_d == HDR_LO) || (state_d == DATA);
      done_q    <= (state_d == DONE);
      err_q     <= (state_d == ERR);
    end
  end

  assign cpu_rst    = cpu_rst_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_prog_load_ctrl.sv
module tb_prog_load_ctrl;
  logic        clk = 1'b0;
  logic        reset, mode_sw, rx_valid;
  logic [7:0]  rx_data;
  logic        cpu_rst, imem_we, busy, done, err;
  logic [13:0] imem_addr;
  logic [31:0] imem_wdata;

  int checks = 0;
  int errors = 0;

  logic [13:0] wr_addr [64];
  logic [31:0] wr_data [64];
  int          wr_n = 0;
  int          base;

  prog_load_ctrl #(.IMEM_AW(14), .IMEM_WORDS(16384)) dut (
    .clk(clk), .reset(reset), .mode_sw(mode_sw), .rx_valid(rx_valid),
    .rx_data(rx_data), .cpu_rst(cpu_rst), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Records every cycle with imem_we high; a stretched pulse shows up as an extra write.
  always @(negedge clk) begin
    if (imem_we === 1'b1 && wr_n < 64) begin
      wr_addr[wr_n] = imem_addr;
      wr_data[wr_n] = imem_wdata;
      wr_n = wr_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_burst(input logic [7:0] b [], input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b[i];
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_busy(input string tag);
    for (int i = 0; i < 20 && busy !== 1'b1; i++) @(negedge clk);
    chk(tag, busy, 1);
  endtask

  task automatic drop_sw();
    mode_sw = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [7:0] bb [];
    reset = 1'b1; mode_sw = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_we", imem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_cpu_rst", cpu_rst, 0);

    // Two-word load with gaps between bytes
    base = wr_n;
    mode_sw = 1'b1;
    wait_busy("t1_busy");
    chk("t1_cpu_rst", cpu_rst, 1);
    send(8'h00); send(8'h02);
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    send(8'h9A); send(8'hBC); send(8'hDE); send(8'hF0);
    @(negedge clk);
    chk("t1_nwr", wr_n - base, 2);
    chk("t1_addr0", wr_addr[base], 0);
    chk("t1_data0", wr_data[base], 32'h12345678);
    chk("t1_addr1", wr_addr[base+1], 1);
    chk("t1_data1", wr_data[base+1], 32'h9ABCDEF0);
    chk("t1_done", done, 1);
    chk("t1_busy", busy, 0);
    chk("t1_hold_addr", imem_addr, 1);
    chk("t1_hold_wdata", imem_wdata, 32'h9ABCDEF0);
    send(8'h55);  // ignored in DONE
    chk("t1_done_ignore", wr_n - base, 2);
    drop_sw();
    chk("t1_cpu_rst_off", cpu_rst, 0);
    chk("t1_done_off", done, 0);

    // Byte in IDLE is ignored
    send(8'hAA);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_nwr", wr_n - base, 2);

    // Zero-length header
    base = wr_n;
    mode_sw = 1'b1;
    wait_busy("t2_busy");
    send(8'h00); send(8'h00);
    @(negedge clk);
    chk("t2_done", done, 1);
    chk("t2_nwr", wr_n - base, 0);
    drop_sw();

    // Oversize header: 16385 words
    base = wr_n;
    mode_sw = 1'b1;
    wait_busy("t3_busy");
    send(8'h40); send(8'h01);
    @(negedge clk);
    chk("t3_err", err, 1);
    chk("t3_busy", busy, 0);
    chk("t3_done", done, 0);
    chk("t3_nwr", wr_n - base, 0);
    drop_sw();
    chk("t3_err_off", err, 0);
    chk("t3_cpu_rst", cpu_rst, 0);

    // Exactly IMEM_WORDS is accepted
    mode_sw = 1'b1;
    wait_busy("t3b_busy");
    send(8'h40); send(8'h00);
    @(negedge clk);
    chk("t3b_busy_data", busy, 1);
    chk("t3b_err", err, 0);
    drop_sw();
    chk("t3b_abort_busy", busy, 0);

    // Abort mid-load after 6 data bytes
    base = wr_n;
    mode_sw = 1'b1;
    wait_busy("t4_busy");
    send(8'h00); send(8'h03);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55); send(8'h66);
    mode_sw = 1'b0;
    @(negedge clk);
    chk("t4_still_busy", busy, 1);
    repeat (2) @(negedge clk);
    chk("t4_cpu_rst", cpu_rst, 0);
    chk("t4_busy", busy, 0);
    chk("t4_nwr", wr_n - base, 1);
    chk("t4_data", wr_data[base], 32'h11223344);

    // Back-to-back bytes, one landing in the imem_we cycle
    base = wr_n;
    mode_sw = 1'b1;
    wait_busy("t5_busy");
    bb = '{8'h00, 8'h02, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};
    send_burst(bb, 10);
    @(negedge clk);
    chk("t5_nwr", wr_n - base, 2);
    chk("t5_addr0", wr_addr[base], 0);
    chk("t5_data0", wr_data[base], 32'hA1B2C3D4);
    chk("t5_addr1", wr_addr[base+1], 1);
    chk("t5_data1", wr_data[base+1], 32'hE5F60718);
    chk("t5_done", done, 1);
    drop_sw();

    // Reset mid-load, 4th byte on the reset edge
    base = wr_n;
    mode_sw = 1'b1;
    wait_busy("t6_busy");
    send(8'h00); send(8'h02);
    send(8'h01); send(8'h02); send(8'h03);
    @(negedge clk);
    reset = 1'b1; rx_valid = 1'b1; rx_data = 8'h04;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    chk("t6_nwr", wr_n - base, 0);
    chk("t6_cpu_rst", cpu_rst, 1);
    chk("t6_busy", busy, 0);
    chk("t6_we", imem_we, 0);
    chk("t6_addr", imem_addr, 0);
    chk("t6_wdata", imem_wdata, 0);
    reset = 1'b0;
    wait_busy("t6_busy2");
    send(8'h00); send(8'h01);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    @(negedge clk);
    chk("t6_nwr2", wr_n - base, 1);
    chk("t6_addr2", wr_addr[base], 0);
    chk("t6_data2", wr_data[base], 32'hDEADBEEF);
    chk("t6_done", done, 1);
    drop_sw();
    chk("t6_cpu_rst_off", cpu_rst, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_load_ctrl.md
PROG_LOAD_CTRL -- requirements
Module: prog_load_ctrl

Interface
REQ-001 The block SHALL have parameter IMEM_AW, default 14, giving the instruction-memory word-address width.
REQ-002 The block SHALL have parameter IMEM_WORDS, default 16384, giving the maximum loadable word count.
REQ-003 The block SHALL have port clk, input, 1, the system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1; reset is synchronous, active-high.
REQ-005 The block SHALL have port mode_sw, input, 1, an asynchronous switch; 1 requests download mode.
REQ-006 The block SHALL have port rx_valid, input, 1, a one-cycle strobe marking a received UART byte.
REQ-007 The block SHALL have port rx_data, input, 8, the received byte, valid only when rx_valid=1.
REQ-008 The block SHALL have port cpu_rst, output, 1, which holds the CPU (PC and register file) in reset.
REQ-009 The block SHALL have port imem_we, output, 1, the instruction-memory write enable.
REQ-010 The block SHALL have port imem_addr, output, IMEM_AW, the instruction-memory word address.
REQ-011 The block SHALL have port imem_wdata, output, 32, the instruction-memory write data.
REQ-012 The block SHALL have port busy, output, 1, which is high in states HDR_HI, HDR_LO and DATA.
REQ-013 The block SHALL have port done, output, 1, which is high in state DONE.
REQ-014 The block SHALL have port err, output, 1, which is high in state ERR.

Function
REQ-015 mode_sw SHALL pass through a 2-flop synchronizer; sw_s denotes the synchronized value, valid 2 cycles after an input change.
REQ-016 The FSM SHALL have states IDLE, HDR_HI, HDR_LO, DATA, DONE and ERR; all outputs SHALL be registered.
REQ-017 From IDLE with sw_s=1, the FSM SHALL go to HDR_HI; cpu_rst SHALL be 1 in every state except IDLE.
REQ-018 In HDR_HI, a byte SHALL load N[15:8] and the FSM SHALL go to HDR_LO; in HDR_LO, a byte SHALL load N[7:0].
REQ-019 From HDR_LO, the next state SHALL be: N=0 -> DONE; N>IMEM_WORDS -> ERR; otherwise DATA, with word index and byte count cleared.
REQ-020 In DATA, bytes SHALL assemble big-endian: the first byte of a word goes to bits 31:24 and the fourth to bits 7:0.
REQ-021 On the edge accepting the 4th byte, imem_we SHALL be 1 for exactly one cycle, with imem_addr equal to the word index and imem_wdata equal to the assembled word.
REQ-022 On that same edge, the word index SHALL increment; when the incremented index equals N, the FSM SHALL enter DONE, and the final write pulse coincides with the first DONE cycle.
REQ-023 The byte counter SHALL wrap from 3 to 0; a byte arriving in the cycle imem_we=1 SHALL be accepted normally.
REQ-024 In DONE and ERR, rx_valid SHALL be ignored; the FSM SHALL return to IDLE only when sw_s=0.
REQ-025 On returning to IDLE, cpu_rst SHALL fall, so the CPU restarts at PC 0.
REQ-026 If sw_s=0 in HDR_HI, HDR_LO or DATA, the FSM SHALL abort to IDLE next cycle with no further write; words already written remain in memory.
REQ-027 rx_valid in IDLE SHALL be ignored.
REQ-028 imem_addr and imem_wdata SHALL hold their last values when imem_we=0.

Reset
REQ-029 While reset=1, the FSM SHALL be in IDLE; synchronizer flops, N, the index and the byte count SHALL be 0; imem_we, busy, done and err SHALL be 0; imem_addr and imem_wdata SHALL be 0; cpu_rst SHALL be 1.
REQ-030 On the first cycle after reset, cpu_rst SHALL be 0 if sw_s=0.
REQ-031 Reset asserted mid-load SHALL override all activity on that edge, with no imem_we pulse.

Verification
REQ-032 Set mode_sw=1; send 00 02 12 34 56 78 9A BC DE F0; expect one write of addr 0, data 0x12345678 and one of addr 1, data 0x9ABCDEF0; expect done=1; after mode_sw=0, expect cpu_rst=0.
REQ-033 Send header 00 00; expect DONE with zero imem_we pulses.
REQ-034 Send header 40 01 (16385 words); expect err=1, busy=0, no writes; after mode_sw=0, expect IDLE with err=0.
REQ-035 Send header 00 03, then 6 bytes, then drop mode_sw; expect exactly 1 write, then IDLE with cpu_rst=0 two to three cycles later.
REQ-036 Send bytes on consecutive cycles, including one in the imem_we cycle; expect no byte lost and correct data.
REQ-037 Assert reset after the 3rd data byte; expect no write, all outputs at reset values, and a fresh header required.
